// File: rtl/uart_rx_char_feeder.sv
// uart_rx_char_feeder: 8N1 UART receiver, byte FIFO and renderer strobe.
// Turns a serial byte stream into one clean char/en pulse per character.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx         asynchronous UART line, idles high
//   char       character presented to the renderer
//   en         strobe, renderer consumes on its rising edge
//   frame_err  one-cycle pulse, stop bit sampled low
//   overflow   one-cycle pulse, byte dropped on a full FIFO
//   fifo_count bytes currently held in the FIFO
module uart_rx_char_feeder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int EN_HIGH    = 2,
  parameter int EN_LOW     = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic [7:0]                    char,
  output logic                          en,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int HL  = (EN_HIGH > EN_LOW) ? EN_HIGH : EN_LOW;
  localparam int HW  = $clog2(HL + 1);
  localparam logic [AW:0] FULLV = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    O_IDLE, O_HIGH, O_LOW
  } out_state_t;

  logic          rx_meta;
  logic          rx_s;
  rx_state_t     state;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          wr;

  out_state_t    ostate;
  logic [HW-1:0] hcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // push is registered: the FIFO write lands one edge after the
  // stop-bit sample, with shreg still holding the byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            div_cnt <= '0;
            tcnt    <= '0;
          end
        end
        START: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd7) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= rx_s ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              shreg <= {rx_s, shreg[7:1]};
              bcnt  <= bcnt + 3'd1;
              if (bcnt == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              if (rx_s) begin
                push  <= 1'b1;
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full = (fifo_count == FULLV);
  assign pop  = (ostate == O_IDLE) && (fifo_count != '0);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ostate <= O_IDLE;
      char   <= 8'h00;
      en     <= 1'b0;
      hcnt   <= '0;
    end else begin
      unique case (ostate)
        O_IDLE: begin
          if (pop) begin
            char   <= mem[rptr];
            en     <= 1'b1;
            hcnt   <= '0;
            ostate <= O_HIGH;
          end
        end
        O_HIGH: begin
          if (hcnt == HW'(EN_HIGH - 1)) begin
            en     <= 1'b0;
            hcnt   <= '0;
            ostate <= O_LOW;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        O_LOW: begin
          if (hcnt == HW'(EN_LOW - 1)) begin
            hcnt   <= '0;
            ostate <= O_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: ostate <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_char_feeder.sv
// tb_uart_rx_char_feeder: directed UART frames on two instances,
// a fast-draining one and one with a long en-low gap.
module tb_uart_rx_char_feeder;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 2;
  localparam int BITC     = 16 * DIV;
  localparam int DEPTH    = 4;
  localparam int EH       = 2;
  localparam int EL0      = 2;
  localparam int EL1      = 2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] char0, char1;
  logic       en0, en1, fe0, fe1, ov0, ov1;
  logic [2:0] cnt0, cnt1;

  always #5 clk = ~clk;

  uart_rx_char_feeder #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
    .EN_HIGH(EH), .EN_LOW(EL0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .rx(rx0),
    .char(char0), .en(en0), .frame_err(fe0),
    .overflow(ov0), .fifo_count(cnt0)
  );

  uart_rx_char_feeder #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
    .EN_HIGH(EH), .EN_LOW(EL1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .rx(rx1),
    .char(char1), .en(en1), .frame_err(fe1),
    .overflow(ov1), .fifo_count(cnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] expq0[$];
  logic [7:0] expq1[$];

  logic       p_en[2];
  logic [7:0] p_char[2];
  logic       p_fe[2];
  logic       p_ov[2];
  int         p_cnt[2];
  int         hi_run[2];
  int         lo_run[2];
  int         since[2];
  bit         seen[2];
  bit         must_rise[2];
  int         rises[2];
  int         fe_n[2];
  int         ov_n[2];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic lane_reset(input int k);
    p_en[k]      = 1'b0;
    p_char[k]    = 8'h00;
    p_fe[k]      = 1'b0;
    p_ov[k]      = 1'b0;
    p_cnt[k]     = 0;
    hi_run[k]    = 0;
    lo_run[k]    = 1_000_000;
    since[k]     = 0;
    seen[k]      = 1'b0;
    must_rise[k] = 1'b0;
  endtask

  task automatic lane(input int k);
    logic [7:0] c;
    logic [7:0] want;
    logic       e, f, o;
    int         n, el;
    bit         have;
    if (k == 0) begin
      c = char0; e = en0; f = fe0; o = ov0; n = int'(cnt0); el = EL0;
    end else begin
      c = char1; e = en1; f = fe1; o = ov1; n = int'(cnt1); el = EL1;
    end
    since[k]++;
    if (must_rise[k]) begin
      chk("en_one_after_push", e, 1);
      must_rise[k] = 1'b0;
    end
    if (e && !p_en[k]) begin
      rises[k]++;
      have = (k == 0) ? (expq0.size() != 0) : (expq1.size() != 0);
      chk("en_expected", have, 1);
      if (have) begin
        want = (k == 0) ? expq0.pop_front() : expq1.pop_front();
        chk("char_at_rise", c, want);
      end
      if (seen[k]) chk("rise_gap", since[k] >= EH + el, 1);
      since[k]  = 0;
      seen[k]   = 1'b1;
      hi_run[k] = 1;
    end else begin
      chk("char_stable", c, p_char[k]);
      if (e) hi_run[k]++;
    end
    if (!e && p_en[k]) chk("en_width", hi_run[k], EH);
    lo_run[k] = e ? 0 : lo_run[k] + 1;
    if (p_cnt[k] == 0 && n == 1 && !e && lo_run[k] >= el + 1)
      must_rise[k] = 1'b1;
    if (f) begin
      fe_n[k]++;
      chk("frame_err_width", p_fe[k], 0);
    end
    if (o) begin
      ov_n[k]++;
      chk("overflow_width", p_ov[k], 0);
    end
    if (f || o) chk("pulse_exclusive", f && o, 0);
    chk("count_bound", n <= DEPTH, 1);
    p_en[k]   = e;
    p_char[k] = c;
    p_fe[k]   = f;
    p_ov[k]   = o;
    p_cnt[k]  = n;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      lane_reset(k);
      rises[k] = 0;
      fe_n[k]  = 0;
      ov_n[k]  = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      lane_reset(0);
      lane_reset(1);
    end else begin
      lane(0);
      lane(1);
    end
  end

  task automatic set_rx(input int k, input logic v);
    if (k == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input int k, input logic [7:0] d);
    if (k == 0) expq0.push_back(d);
    else        expq1.push_back(d);
  endtask

  task automatic send(input int k, input logic [7:0] d,
                      input logic stop);
    set_rx(k, 1'b0);
    hold(BITC);
    for (int i = 0; i < 8; i++) begin
      set_rx(k, d[i]);
      hold(BITC);
    end
    set_rx(k, stop);
    hold(BITC);
    set_rx(k, 1'b1);
  endtask

  function automatic bit drained(input int k);
    if (k == 0) return expq0.size() == 0 && cnt0 == 0 && !en0;
    return expq1.size() == 0 && cnt1 == 0 && !en1;
  endfunction

  task automatic wait_drain(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drained(k)) break;
    end
    chk("drain_in_budget", drained(k), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_char0"}, char0, 0);
    chk({tag, "_en0"}, en0, 0);
    chk({tag, "_fe0"}, fe0, 0);
    chk({tag, "_ov0"}, ov0, 0);
    chk({tag, "_cnt0"}, cnt0, 0);
    chk({tag, "_char1"}, char1, 0);
    chk({tag, "_en1"}, en1, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
  endtask

  logic [7:0] hello [10];
  int r0, f0;

  initial begin
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
              8'h0D, 8'h0A, 8'h41, 8'h42, 8'h7E};
    reset_n = 1'b0;
    hold(3);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    hold(5);

    // single byte
    expect_byte(0, 8'h41);
    send(0, 8'h41, 1'b1);
    wait_drain(0, 500);
    chk("single_char", char0, 8'h41);
    chk("single_rises", rises[0], 1);
    chk("single_fe", fe_n[0], 0);
    chk("single_cnt", cnt0, 0);

    // start-bit glitch, then CR
    r0 = rises[0];
    rx0 = 1'b0;
    hold(3 * DIV);
    rx0 = 1'b1;
    hold(300);
    chk("glitch_rises", rises[0], r0);
    chk("glitch_cnt", cnt0, 0);
    expect_byte(0, 8'h0D);
    send(0, 8'h0D, 1'b1);
    wait_drain(0, 500);
    chk("glitch_next_char", char0, 8'h0D);
    chk("glitch_next_rises", rises[0], r0 + 1);

    // framing error with a break, then '1'
    r0 = rises[0];
    f0 = fe_n[0];
    send(0, 8'h55, 1'b0);
    rx0 = 1'b0;
    hold(BITC);
    rx0 = 1'b1;
    hold(2 * BITC);
    chk("ferr_pulses", fe_n[0], f0 + 1);
    chk("ferr_no_en", rises[0], r0);
    expect_byte(0, 8'h31);
    send(0, 8'h31, 1'b1);
    wait_drain(0, 500);
    chk("ferr_next_char", char0, 8'h31);
    chk("ferr_total", fe_n[0], f0 + 1);

    // overflow on the slow-draining instance
    for (int i = 0; i < 5; i++) expect_byte(1, 8'h61 + 8'(i));
    for (int i = 0; i < 6; i++) send(1, 8'h61 + 8'(i), 1'b1);
    chk("ovf_count_full", cnt1, 4);
    chk("ovf_pulses", ov_n[1], 1);
    chk("ovf_first_char", char1, 8'h61);
    chk("ovf_fe", fe_n[1], 0);
    wait_drain(1, 12000);
    chk("ovf_last_char", char1, 8'h65);
    chk("ovf_rises", rises[1], 5);
    chk("ovf_pulses_end", ov_n[1], 1);

    // back-to-back string
    r0 = rises[0];
    for (int i = 0; i < 10; i++) expect_byte(0, hello[i]);
    for (int i = 0; i < 10; i++) send(0, hello[i], 1'b1);
    wait_drain(0, 1000);
    chk("b2b_rises", rises[0], r0 + 10);
    chk("b2b_last", char0, 8'h7E);
    chk("b2b_no_ovf", ov_n[0], 0);

    // reset during bit 4 of 0x7E, then '0'
    r0 = rises[0];
    rx0 = 1'b0;
    hold(BITC);
    for (int i = 0; i < 4; i++) begin
      rx0 = (i == 0) ? 1'b0 : 1'b1;
      hold(BITC);
    end
    rx0 = 1'b1;
    hold(BITC / 2);
    reset_n = 1'b0;
    hold(2);
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    hold(200);
    chk("midrst_rises", rises[0], r0);
    chk("midrst_cnt", cnt0, 0);
    chk("midrst_char", char0, 0);
    expect_byte(0, 8'h30);
    send(0, 8'h30, 1'b1);
    wait_drain(0, 500);
    chk("midrst_next_char", char0, 8'h30);
    chk("midrst_rises_end", rises[0], r0 + 1);

    chk("queue0_empty", expq0.size(), 0);
    chk("queue1_empty", expq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
